// File: rtl/zeus_bus_pkg.sv
// Shared types and default bus timing for the phi2 bus cycle sequencer.
// All cycle constants are clk counts within one phi2 phase (0..11 at 166.67 MHz).
package zeus_bus_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } bus_state_t;

    localparam logic [11:0] DEF_PHI2_PULSE_CYCLE_COUNT = 12'd11;
    localparam logic [11:0] DEF_BANK_LATCH_CYCLE       = 12'd2;
    localparam logic [11:0] DEF_WRITE_START_CYCLE      = 12'd1;
    localparam logic [11:0] DEF_WRITE_END_CYCLE        = 12'd10;
    localparam logic [11:0] DEF_READ_SAMPLE_CYCLE      = 12'd10;
    localparam logic [7:0]  DEF_MAX_WAIT               = 8'd15;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/phi2_edge_detect.sv
// Single-clk rise/fall strobes of the phi2 level, decoded against a one-clk delayed copy.
module phi2_edge_detect (
    input  logic clk,
    input  logic clk_phi2,
    output logic phi2_rise,
    output logic phi2_fall
);

    logic phi2_reg;

    // No reset needed: the delayed copy simply follows the level every clk.
    always_ff @(posedge clk) begin
        phi2_reg <= clk_phi2;
    end

    assign phi2_rise = clk_phi2 & ~phi2_reg;
    assign phi2_fall = ~clk_phi2 & phi2_reg;

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Sequences 65xx-style bus cycles on phi2: bank latch, read/write strobes,
// peripheral request/ack handshake with wait states and timeout.
module bus_cycle_sequencer
    import zeus_bus_pkg::*;
#(
    parameter logic [11:0] PHI2_PULSE_CYCLE_COUNT = DEF_PHI2_PULSE_CYCLE_COUNT,
    parameter logic [11:0] BANK_LATCH_CYCLE       = DEF_BANK_LATCH_CYCLE,
    parameter logic [11:0] WRITE_START_CYCLE      = DEF_WRITE_START_CYCLE,
    parameter logic [11:0] WRITE_END_CYCLE        = DEF_WRITE_END_CYCLE,
    parameter logic [11:0] READ_SAMPLE_CYCLE      = DEF_READ_SAMPLE_CYCLE,
    parameter logic [7:0]  MAX_WAIT               = DEF_MAX_WAIT,
    parameter logic [15:0] BUS_CYCLE_COUNT_INIT   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_phi2,
    input  logic [11:0] phi2_cycle,
    input  logic        cpu_vda,
    input  logic        cpu_vpa,
    input  logic        cpu_rwb,
    input  logic        periph_ack,
    output logic        phi2_rise,
    output logic        phi2_fall,
    output logic        bank_latch,
    output logic        rd_strobe,
    output logic        wr_strobe,
    output logic        wr_active,
    output logic        periph_req,
    output logic        cpu_rdy,
    output logic        bus_error,
    output logic [7:0]  wait_count,
    output logic [15:0] bus_cycle_count
);

    bus_state_t  state_reg;
    logic        pending_reg;
    logic        acked_reg;
    logic        rwb_reg;
    logic        bank_latch_reg;
    logic        rd_strobe_reg;
    logic        wr_strobe_reg;
    logic        wr_active_reg;
    logic        periph_req_reg;
    logic        cpu_rdy_reg;
    logic        bus_error_reg;
    logic [7:0]  wait_count_reg;
    logic [15:0] bus_cycle_count_reg;

    logic        phase_low;
    logic        phase_high;
    logic        cycle_ok;
    logic        addr_valid;
    logic        ack_seen;
    logic        acked_now;
    logic        start_access;
    logic        sample_point;
    logic        in_wr_window;
    logic [7:0]  wait_inc;
    logic        timeout;

    phi2_edge_detect u_edge (
        .clk       (clk),
        .clk_phi2  (clk_phi2),
        .phi2_rise (phi2_rise),
        .phi2_fall (phi2_fall)
    );

    // Phase the current clk belongs to, so cycle 0 of a phase decodes under
    // the new phase rather than the one the state register still holds.
    assign phase_low  = (state_reg == ST_LOW  && !phi2_rise) ||
                        (state_reg != ST_LOW  &&  phi2_fall);
    assign phase_high = (state_reg == ST_HIGH && !phi2_fall) ||
                        (state_reg == ST_LOW  &&  phi2_rise);

    assign cycle_ok     = (phi2_cycle <= PHI2_PULSE_CYCLE_COUNT);
    assign addr_valid   = cpu_vda | cpu_vpa;
    assign ack_seen     = periph_req_reg & periph_ack;
    assign acked_now    = acked_reg | ack_seen;
    assign start_access = phi2_rise & (state_reg == ST_LOW) & addr_valid & ~pending_reg;
    assign sample_point = phase_high & cycle_ok & pending_reg &
                          (phi2_cycle == READ_SAMPLE_CYCLE);
    assign in_wr_window = phase_high & cycle_ok & pending_reg & ~rwb_reg &
                          (phi2_cycle >= WRITE_START_CYCLE) &
                          (phi2_cycle <= WRITE_END_CYCLE);
    assign wait_inc     = sat_inc8(wait_count_reg);
    assign timeout      = (wait_inc >= MAX_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= ST_SYNC;
            pending_reg         <= 1'b0;
            acked_reg           <= 1'b0;
            rwb_reg             <= 1'b1;
            bank_latch_reg      <= 1'b0;
            rd_strobe_reg       <= 1'b0;
            wr_strobe_reg       <= 1'b0;
            wr_active_reg       <= 1'b0;
            periph_req_reg      <= 1'b0;
            cpu_rdy_reg         <= 1'b1;
            bus_error_reg       <= 1'b0;
            wait_count_reg      <= 8'd0;
            bus_cycle_count_reg <= BUS_CYCLE_COUNT_INIT;
        end else begin
            unique case (state_reg)
                ST_SYNC: if (phi2_fall) state_reg <= ST_LOW;
                ST_LOW:  if (phi2_rise) state_reg <= ST_HIGH;
                ST_HIGH: if (phi2_fall) state_reg <= ST_LOW;
                default: state_reg <= ST_SYNC;
            endcase

            if (phi2_fall && state_reg != ST_SYNC) begin
                bus_cycle_count_reg <= bus_cycle_count_reg + 16'd1;
            end

            bank_latch_reg <= phase_low & cycle_ok & addr_valid & ~pending_reg &
                              (phi2_cycle == BANK_LATCH_CYCLE);
            wr_active_reg  <= in_wr_window;
            wr_strobe_reg  <= in_wr_window & acked_now & (phi2_cycle == WRITE_END_CYCLE);
            rd_strobe_reg  <= 1'b0;
            bus_error_reg  <= 1'b0;

            if (ack_seen) begin
                acked_reg      <= 1'b1;
                periph_req_reg <= 1'b0;
            end

            if (start_access) begin
                pending_reg    <= 1'b1;
                acked_reg      <= 1'b0;
                rwb_reg        <= cpu_rwb;
                periph_req_reg <= 1'b1;
                wait_count_reg <= 8'd0;
            end else if (sample_point) begin
                if (acked_now) begin
                    rd_strobe_reg <= rwb_reg;
                    cpu_rdy_reg   <= 1'b1;
                    pending_reg   <= 1'b0;
                    acked_reg     <= 1'b0;
                end else if (timeout) begin
                    // Give up: release the CPU and retire the access without strobes.
                    bus_error_reg  <= 1'b1;
                    periph_req_reg <= 1'b0;
                    cpu_rdy_reg    <= 1'b1;
                    pending_reg    <= 1'b0;
                    wait_count_reg <= wait_inc;
                end else begin
                    cpu_rdy_reg    <= 1'b0;
                    wait_count_reg <= wait_inc;
                end
            end
        end
    end

    assign bank_latch      = bank_latch_reg;
    assign rd_strobe       = rd_strobe_reg;
    assign wr_strobe       = wr_strobe_reg;
    assign wr_active       = wr_active_reg;
    assign periph_req      = periph_req_reg;
    assign cpu_rdy         = cpu_rdy_reg;
    assign bus_error       = bus_error_reg;
    assign wait_count      = wait_count_reg;
    assign bus_cycle_count = bus_cycle_count_reg;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer: stimulus queues expected bus events,
// a negedge monitor pops and compares them as the DUT produces strobes.
module tb_bus_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_phi2 = 1'b1;
    logic [11:0] phi2_cycle = 12'd0;
    logic        cpu_vda = 1'b0;
    logic        cpu_vpa = 1'b0;
    logic        cpu_rwb = 1'b1;
    logic        periph_ack = 1'b0;

    logic        phi2_rise, phi2_fall, bank_latch, rd_strobe, wr_strobe, wr_active;
    logic        periph_req, cpu_rdy, bus_error;
    logic [7:0]  wait_count;
    logic [15:0] bus_cycle_count;

    logic        w_rise, w_fall, w_bank, w_rd, w_wr, w_wra, w_req, w_rdy, w_err;
    logic [7:0]  w_wc;
    logic [15:0] w_bcc;

    bus_cycle_sequencer dut (
        .clk(clk), .reset(reset), .clk_phi2(clk_phi2), .phi2_cycle(phi2_cycle),
        .cpu_vda(cpu_vda), .cpu_vpa(cpu_vpa), .cpu_rwb(cpu_rwb), .periph_ack(periph_ack),
        .phi2_rise(phi2_rise), .phi2_fall(phi2_fall), .bank_latch(bank_latch),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .wr_active(wr_active),
        .periph_req(periph_req), .cpu_rdy(cpu_rdy), .bus_error(bus_error),
        .wait_count(wait_count), .bus_cycle_count(bus_cycle_count)
    );

    // Second instance with a preset counter so the 16-bit wrap is reached in a few falls.
    bus_cycle_sequencer #(.BUS_CYCLE_COUNT_INIT(16'hFFFC)) u_wrap (
        .clk(clk), .reset(reset), .clk_phi2(clk_phi2), .phi2_cycle(phi2_cycle),
        .cpu_vda(cpu_vda), .cpu_vpa(cpu_vpa), .cpu_rwb(cpu_rwb), .periph_ack(periph_ack),
        .phi2_rise(w_rise), .phi2_fall(w_fall), .bank_latch(w_bank),
        .rd_strobe(w_rd), .wr_strobe(w_wr), .wr_active(w_wra),
        .periph_req(w_req), .cpu_rdy(w_rdy), .bus_error(w_err),
        .wait_count(w_wc), .bus_cycle_count(w_bcc)
    );

    always #3 clk = ~clk;

    typedef enum int {EV_BANK, EV_RD, EV_WR, EV_ERR, EV_WIN} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       lvl;
        int       wc;
        int       low;
        int       len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_delay = -1;
    int   req_clks = 0;
    int   cyc_d = 0;
    logic lvl_d = 1'b1;
    int   low_clks = 0;
    int   run = 0;
    int   win_start = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void expect_ev(input ev_kind_t k, input int cyc, input int lvl,
                                      input int wc, input int low, input int len);
        exp_t e;
        e.kind = k; e.cyc = cyc; e.lvl = lvl; e.wc = wc; e.low = low; e.len = len;
        sb.push_back(e);
    endfunction

    task automatic pop_check(input ev_kind_t k);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("unexpected_%s", k.name()), 1, 0);
            return;
        end
        e = sb.pop_front();
        check($sformatf("kind_%s", k.name()), int'(k), int'(e.kind));
        if (k == EV_WIN) begin
            check("win_start", win_start, e.cyc);
            check("win_len", run, e.len);
        end else begin
            check("cycle", cyc_d, e.cyc);
            check("phase_level", int'(lvl_d), e.lvl);
            if (k != EV_BANK) begin
                check("wait_count", int'(wait_count), e.wc);
                check("rdy_low_clks", low_clks, e.low);
                low_clks = 0;
            end
            if (k == EV_ERR) begin
                check("err_periph_req", int'(periph_req), 0);
                check("err_cpu_rdy", int'(cpu_rdy), 1);
            end
        end
        $display("txn %s cyc=%0d wc=%0d len=%0d t=%0t", k.name(),
                 (k == EV_WIN) ? win_start : cyc_d, wait_count, run, $time);
    endtask

    // phi2 generator: 12 clks per phase, level toggles when the count wraps.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (phi2_cycle == 12'd11) begin
                phi2_cycle = 12'd0;
                clk_phi2 = ~clk_phi2;
            end else begin
                phi2_cycle = phi2_cycle + 12'd1;
            end
        end
    end

    // Peripheral model: ack after ack_delay clks of request, never if negative.
    initial begin
        forever begin
            @(negedge clk);
            if (periph_req && ack_delay >= 0) begin
                req_clks++;
                periph_ack = (req_clks > ack_delay);
            end else begin
                req_clks = 0;
                periph_ack = 1'b0;
            end
        end
    end

    // Monitor: registered outputs reflect the phi2 cycle seen at the previous negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                low_clks = 0;
                run = 0;
            end else begin
                if ((clk_phi2 && !lvl_d) || phi2_rise)
                    check("phi2_rise", int'(phi2_rise), int'(clk_phi2 & ~lvl_d));
                if ((!clk_phi2 && lvl_d) || phi2_fall)
                    check("phi2_fall", int'(phi2_fall), int'(~clk_phi2 & lvl_d));
                if (!cpu_rdy) low_clks++;
                if (bank_latch) pop_check(EV_BANK);
                if (rd_strobe)  pop_check(EV_RD);
                if (wr_strobe)  pop_check(EV_WR);
                if (bus_error)  pop_check(EV_ERR);
                if (wr_active) begin
                    if (run == 0) win_start = cyc_d;
                    run++;
                end else if (run > 0) begin
                    pop_check(EV_WIN);
                    run = 0;
                end
            end
            cyc_d = int'(phi2_cycle);
            lvl_d = clk_phi2;
        end
    end

    task automatic wait_gen(input logic lvl, input int cyc);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (clk_phi2 == lvl && int'(phi2_cycle) == cyc) return;
        end
        check("wait_gen_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1200 && sb.size() != 0; i++) @(posedge clk);
        check("drain_pending_events", sb.size(), 0);
    endtask

    task automatic run_access(input logic vda, input logic vpa, input logic rwb,
                              input int delay, input int hold);
        wait_gen(1'b0, 0);
        ack_delay = delay;
        cpu_vda = vda;
        cpu_vpa = vpa;
        cpu_rwb = rwb;
        for (int h = 0; h < hold; h++) wait_gen(1'b1, 1);
        cpu_vda = 1'b0;
        cpu_vpa = 1'b0;
        wait_drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_cpu_rdy", int'(cpu_rdy), 1);
        check("rst_periph_req", int'(periph_req), 0);
        check("rst_wait_count", int'(wait_count), 0);
        check("rst_bus_cycle_count", int'(bus_cycle_count), 0);
        check("rst_strobes", int'({bank_latch, rd_strobe, wr_strobe, wr_active, bus_error}), 0);
        check("rst_wrap_preset", int'(w_bcc), 32'hFFFC);

        // Release reset in the middle of a high phase.
        wait_gen(1'b1, 5);
        reset = 1'b0;
        for (int f = 1; f <= 6; f++) begin
            wait_gen(1'b0, 3);
            check($sformatf("bus_cycle_count_fall%0d", f), int'(bus_cycle_count), f - 1);
            check($sformatf("wrap_count_fall%0d", f), int'(w_bcc), (32'hFFFC + f - 1) & 32'hFFFF);
        end

        // Read via vpa, ack 3 clks after request.
        expect_ev(EV_BANK, 2, 0, 0, 0, 0);
        expect_ev(EV_RD, 10, 1, 0, 0, 0);
        run_access(1'b0, 1'b1, 1'b1, 3, 1);

        // Write via vda, immediate ack.
        expect_ev(EV_BANK, 2, 0, 0, 0, 0);
        expect_ev(EV_WR, 10, 1, 0, 0, 0);
        expect_ev(EV_WIN, 1, 1, 0, 0, 10);
        run_access(1'b1, 1'b0, 1'b0, 0, 1);

        // Read acked in the second high phase; vda held so a pending access blocks the latch.
        expect_ev(EV_BANK, 2, 0, 0, 0, 0);
        expect_ev(EV_RD, 10, 1, 1, 24, 0);
        run_access(1'b1, 1'b0, 1'b1, 15, 2);

        // Read never acked: timeout at wait_count 15.
        expect_ev(EV_BANK, 2, 0, 0, 0, 0);
        expect_ev(EV_ERR, 10, 1, 15, 336, 0);
        run_access(1'b1, 1'b0, 1'b1, -1, 1);

        // Ack sampled on the read sample cycle itself.
        expect_ev(EV_BANK, 2, 0, 0, 0, 0);
        expect_ev(EV_RD, 10, 1, 0, 0, 0);
        run_access(1'b1, 1'b0, 1'b1, 9, 1);

        // Write with one wait state: window repeats, strobe only once acked.
        expect_ev(EV_BANK, 2, 0, 0, 0, 0);
        expect_ev(EV_WIN, 1, 1, 0, 0, 10);
        expect_ev(EV_WR, 10, 1, 1, 24, 0);
        expect_ev(EV_WIN, 1, 1, 0, 0, 10);
        run_access(1'b1, 1'b0, 1'b0, 15, 1);

        // Reset during a waiting read: access abandoned silently.
        expect_ev(EV_BANK, 2, 0, 0, 0, 0);
        wait_gen(1'b0, 0);
        ack_delay = -1;
        cpu_vda = 1'b1;
        cpu_rwb = 1'b1;
        wait_gen(1'b1, 1);
        cpu_vda = 1'b0;
        wait_gen(1'b1, 11);
        check("wait_cpu_rdy", int'(cpu_rdy), 0);
        check("wait_count_one", int'(wait_count), 1);
        check("wait_periph_req", int'(periph_req), 1);
        wait_gen(1'b0, 5);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        check("abandon_periph_req", int'(periph_req), 0);
        check("abandon_cpu_rdy", int'(cpu_rdy), 1);
        check("abandon_wait_count", int'(wait_count), 0);
        repeat (420) @(posedge clk);
        check("final_queue_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_cycle_sequencer.md
BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

Interface
REQ-001 SHALL have parameter PHI2_PULSE_CYCLE_COUNT, default 12'd11, last phi2_cycle value of each phi2 phase (phase = 12 clk cycles).
REQ-002 SHALL have parameter BANK_LATCH_CYCLE, default 12'd2, phi2-low cycle at which bank_latch pulses.
REQ-003 SHALL have parameter WRITE_START_CYCLE, default 12'd1, first phi2-high cycle of wr_active.
REQ-004 SHALL have parameter WRITE_END_CYCLE, default 12'd10, last phi2-high cycle of wr_active.
REQ-005 SHALL have parameter READ_SAMPLE_CYCLE, default 12'd10, phi2-high cycle of rd_strobe and ready decision.
REQ-006 SHALL have parameter MAX_WAIT, default 8'd15, wait-state limit before forced completion.
REQ-007 Ports: clk  in  1  system clock (166.67 MHz); single clock domain.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 clk_phi2  in  1  bus clock level, generated in the clk domain.
REQ-010 phi2_cycle  in  12  clk count within current phi2 phase.
REQ-011 cpu_vda, cpu_vpa, cpu_rwb  in  1 each  CPU valid-data/valid-program address, read(1)/write(0).
REQ-012 periph_ack  in  1  peripheral access complete.
REQ-013 phi2_rise, phi2_fall  out  1 each  single-clk edge strobes.
REQ-014 bank_latch, rd_strobe, wr_strobe  out  1 each  single-clk strobes; wr_active  out  1  write window level.
REQ-015 periph_req  out  1  access request level; cpu_rdy  out  1  CPU RDY.
REQ-016 bus_error  out  1  single-clk timeout pulse; wait_count  out  8; bus_cycle_count  out  16.

Function
REQ-017 SHALL register clk_phi2 once; phi2_rise = clk_phi2 & !prev, phi2_fall = !clk_phi2 & prev, combinational from that register.
REQ-018 SHALL have states SYNC, LOW, HIGH; SYNC->LOW on phi2_fall only; LOW->HIGH on phi2_rise; HIGH->LOW on phi2_fall.
REQ-019 In SYNC, bank_latch, rd_strobe, wr_strobe, wr_active, periph_req SHALL stay 0; edge strobes still operate.
REQ-020 In LOW, bank_latch SHALL pulse when phi2_cycle==BANK_LATCH_CYCLE and (cpu_vda|cpu_vpa) and no access pending.
REQ-021 On phi2_rise with (cpu_vda|cpu_vpa), SHALL capture cpu_rwb and assert periph_req next clk, unless an access is already pending.
REQ-022 periph_req SHALL hold until the clk after periph_ack is sampled high; periph_ack with periph_req low SHALL be ignored.
REQ-023 Ack arriving on the same clk periph_req rises SHALL be accepted.
REQ-024 In HIGH at READ_SAMPLE_CYCLE, if acked and captured read: rd_strobe pulses 1 clk.
REQ-025 In HIGH for WRITE_START_CYCLE..WRITE_END_CYCLE inclusive, captured write: wr_active=1; wr_strobe pulses at WRITE_END_CYCLE only if acked.
REQ-026 At READ_SAMPLE_CYCLE in HIGH with access pending and unacked: cpu_rdy<=0, wait_count increments (saturating 8-bit), access stays pending, strobes suppressed.
REQ-027 While pending, each later HIGH phase SHALL re-evaluate at READ_SAMPLE_CYCLE; on ack, strobes per REQ-024/025 and cpu_rdy<=1.
REQ-028 When wait_count reaches MAX_WAIT unacked at READ_SAMPLE_CYCLE: bus_error pulses, periph_req drops, cpu_rdy<=1, no rd/wr strobe, access retired.
REQ-029 wait_count SHALL clear at start of each new access (REQ-021).
REQ-030 bus_cycle_count SHALL increment on every phi2_fall outside SYNC, wrap 16'hFFFF->0.
REQ-031 Ack coincident with READ_SAMPLE_CYCLE SHALL count as acked (no wait state).

Reset
REQ-032 On reset: state SYNC, all strobes/levels 0, cpu_rdy=1, wait_count=0, bus_cycle_count=0, pending cleared.
REQ-033 Reset mid-access SHALL abandon the access without bus_error or strobes.

Structure
REQ-034 Package zeus_bus_pkg SHALL hold the state enum and default timing constants.
REQ-035 One sub-module phi2_edge_detect SHALL implement REQ-017.

Verification
REQ-036 Reset released mid phi2-high -> no strobes until first phi2_fall; bus_cycle_count=0 then 1 at second fall.
REQ-037 vpa=1, rwb=1, ack 3 clks after req -> bank_latch at low cycle 2, rd_strobe at high cycle 10, cpu_rdy stays 1, wait_count=0.
REQ-038 vda=1, rwb=0, ack immediate -> wr_active high cycles 1..10 (10 clks), wr_strobe at cycle 10.
REQ-039 Read, ack in second HIGH phase -> cpu_rdy 0 for one bus cycle, wait_count=1, single rd_strobe in second phase.
REQ-040 Read, no ack -> bus_error pulse once at wait_count=15, periph_req=0, cpu_rdy=1, no rd_strobe.
REQ-041 bus_cycle_count preset via 65536 phi2 falls -> wraps to 0.
